lsu: RTL
========

LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter: TIMEOUT, 255, maximum cycles spent in BUSY waiting for mem_resp before aborting.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  EX stage presents a load/store.
REQ-005 req_ready  output  1  LSU can accept a request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 half, 10 word, 11 double.
REQ-008 req_unsigned  input  1  load zero-extends when 1; ignored for stores.
REQ-009 req_addr  input  64  byte address.
REQ-010 req_wdata  input  64  store data, right-justified.
REQ-011 mem_ce  output  1  memory access enable.
REQ-012 mem_we  output  1  memory write enable.
REQ-013 mem_addr  output  64  8-byte-aligned address (req_addr with [2:0] cleared).
REQ-014 mem_wdata  output  64  lane-shifted store data.
REQ-015 mem_wmask  output  8  byte-lane write mask.
REQ-016 mem_rdata  input  64  memory read data, valid when mem_resp=1.
REQ-017 mem_resp  input  1  memory completes the current access.
REQ-018 resp_valid  output  1  result available to WB.
REQ-019 resp_ready  input  1  WB accepts the result.
REQ-020 resp_data  output  64  extended load data; 0 for stores.
REQ-021 resp_err  output  1  misaligned access or timeout.

Function
REQ-022 The FSM SHALL have states IDLE, BUSY, DONE; req_ready = (state==IDLE).
REQ-023 IDLE: on req_valid, the LSU SHALL register the request fields; if addr[2:0] mod (1<<size) != 0, go to DONE with err=1 and no memory access; else go to BUSY.
REQ-024 BUSY: mem_ce=1, mem_we/addr/wdata/wmask SHALL be driven from registered fields and held stable until mem_resp.
REQ-025 mem_wmask SHALL equal ((1<<(1<<size))-1) << addr[2:0] for stores and 8'h00 for loads.
REQ-026 mem_wdata SHALL equal req_wdata << (8*addr[2:0]), truncated to 64 bits.
REQ-027 On mem_resp in BUSY, the LSU SHALL compute resp_data = mem_rdata >> (8*addr[2:0]), truncated to the access size, then sign- or zero-extended to 64 bits (double: no extension); stores yield 0; go to DONE, err=0.
REQ-028 A BUSY cycle counter SHALL start at 0 on entry; if it reaches TIMEOUT without mem_resp, the LSU SHALL drop mem_ce and go to DONE with err=1, resp_data=0.
REQ-029 mem_resp in the same cycle the counter reaches TIMEOUT SHALL count as success.
REQ-030 DONE: resp_valid=1, resp_data/resp_err held until resp_ready; on resp_ready go to IDLE; no new request is accepted in the same cycle.
REQ-031 mem_ce SHALL be 0 in IDLE and DONE; mem_resp outside BUSY SHALL be ignored.
REQ-032 Minimum latency: request accepted cycle N, mem_resp in N+1, resp_valid in N+2.

Reset
REQ-033 On reset the state SHALL be IDLE, counter 0, and mem_ce, mem_we, mem_wmask, resp_valid, resp_err, resp_data, mem_addr, mem_wdata SHALL be 0.
REQ-034 Reset during BUSY or DONE SHALL abandon the access and drop mem_ce in the next cycle; no response is produced.

Structure
REQ-035 A shared package SHALL hold the size encodings (SZ_B/H/W/D) and the FSM state enum.
REQ-036 A single sub-module lsu_align SHALL implement combinational mask generation, store shifting and load extraction/extension.

Verification
REQ-037 SB at addr 0x1003, wdata 0xAB, mem_resp next cycle -> mem_wmask=0x08, mem_wdata=0xAB000000, mem_addr=0x1000, resp_err=0.
REQ-038 LH signed at 0x2006, mem_rdata=0x8001_0000_0000_0000 -> resp_data=0xFFFF_FFFF_FFFF_8001; LHU same -> 0x8001.
REQ-039 LW at 0x3002 -> resp_err=1 next cycle, mem_ce never asserted.
REQ-040 LD at 0x4000 with mem_resp withheld, TIMEOUT=4 -> mem_ce high exactly 4 cycles, then resp_valid=1, resp_err=1.
REQ-041 SD completes, resp_ready held low 3 cycles -> resp_valid stays 1 and req_ready stays 0 until handshake.
REQ-042 Reset asserted in BUSY -> mem_ce=0 and req_ready=1 the cycle after; no resp_valid.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared LSU definitions: access-size encodings, FSM states and alignment helpers.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_bits(input logic [1:0] size);
        case (size)
            SZ_B:    align_bits = 3'b000;
            SZ_H:    align_bits = 3'b001;
            SZ_W:    align_bits = 3'b011;
            default: align_bits = 3'b111;
        endcase
    endfunction

    // Contiguous byte enables for an access of the given size, before lane shift.
    function automatic logic [7:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_B:    size_bytes = 8'h01;
            SZ_H:    size_bytes = 8'h03;
            SZ_W:    size_bytes = 8'h0F;
            default: size_bytes = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: misalignment detect, store mask/shift, load extract/extend.
import lsu_pkg::*;

module lsu_align (
    input  logic [1:0]  size,
    input  logic [2:0]  off,
    input  logic        we,
    input  logic        uns,
    input  logic [63:0] wdata,
    input  logic [63:0] rdata,
    output logic        misaligned,
    output logic [7:0]  wmask,
    output logic [63:0] wdata_sh,
    output logic [63:0] rdata_ext
);

    logic [63:0] sh;
    logic        sx;

    always_comb begin
        misaligned = (off & align_bits(size)) != 3'b000;
        wmask      = we ? (size_bytes(size) << off) : 8'h00;
        wdata_sh   = wdata << {off, 3'b000};
        sh         = rdata >> {off, 3'b000};
        sx         = 1'b0;
        rdata_ext  = 64'h0;
        if (!we) begin
            case (size)
                SZ_B: begin
                    sx        = ~uns & sh[7];
                    rdata_ext = {{56{sx}}, sh[7:0]};
                end
                SZ_H: begin
                    sx        = ~uns & sh[15];
                    rdata_ext = {{48{sx}}, sh[15:0]};
                end
                SZ_W: begin
                    sx        = ~uns & sh[31];
                    rdata_ext = {{32{sx}}, sh[31:0]};
                end
                default: rdata_ext = sh;
            endcase
        end
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding access, aligned 64-bit memory port, bounded wait.
import lsu_pkg::*;

module lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        mem_ce,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic [63:0] mem_rdata,
    input  logic        mem_resp,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_data,
    output logic        resp_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          r_we, r_uns;
    logic [1:0]    r_size;
    logic [2:0]    r_off;

    logic          a_we, a_uns, a_mis;
    logic [1:0]    a_size;
    logic [2:0]    a_off;
    logic [7:0]    a_wmask;
    logic [63:0]   a_wdata, a_rdata;

    // One aligner serves both phases: live request fields in IDLE, latched ones after.
    assign a_we   = (state == IDLE) ? req_we        : r_we;
    assign a_uns  = (state == IDLE) ? req_unsigned  : r_uns;
    assign a_size = (state == IDLE) ? req_size      : r_size;
    assign a_off  = (state == IDLE) ? req_addr[2:0] : r_off;

    assign req_ready = (state == IDLE);

    lsu_align u_align (
        .size       (a_size),
        .off        (a_off),
        .we         (a_we),
        .uns        (a_uns),
        .wdata      (req_wdata),
        .rdata      (mem_rdata),
        .misaligned (a_mis),
        .wmask      (a_wmask),
        .wdata_sh   (a_wdata),
        .rdata_ext  (a_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            r_we       <= 1'b0;
            r_uns      <= 1'b0;
            r_size     <= SZ_B;
            r_off      <= 3'b000;
            mem_ce     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 64'h0;
            mem_wdata  <= 64'h0;
            mem_wmask  <= 8'h00;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_data  <= 64'h0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    r_we   <= req_we;
                    r_uns  <= req_unsigned;
                    r_size <= req_size;
                    r_off  <= req_addr[2:0];
                    if (a_mis) begin
                        state      <= DONE;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_data  <= 64'h0;
                    end else begin
                        state     <= BUSY;
                        cnt       <= '0;
                        mem_ce    <= 1'b1;
                        mem_we    <= req_we;
                        mem_addr  <= {req_addr[63:3], 3'b000};
                        mem_wdata <= a_wdata;
                        mem_wmask <= a_wmask;
                    end
                end
                BUSY: begin
                    // A response on the final allowed cycle still wins over the timeout.
                    if (mem_resp || cnt == CW'(TIMEOUT - 1)) begin
                        state      <= DONE;
                        mem_ce     <= 1'b0;
                        mem_we     <= 1'b0;
                        mem_wmask  <= 8'h00;
                        resp_valid <= 1'b1;
                        resp_err   <= ~mem_resp;
                        resp_data  <= mem_resp ? a_rdata : 64'h0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: if (resp_ready) begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_data  <= 64'h0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
